// File: rtl/bus_to_sample_pkg.sv
// Shared types, sizes and byte-select helper for the 64-bit word to byte-stream unpacker.
package bus_to_sample_pkg;

  typedef enum logic {IDLE, SHIFT} state_e;

  localparam int unsigned BYTES_PER_WORD = 8;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 64;

  // Byte k of a word lives at word[8k+7:8k].
  function automatic logic [BYTE_W-1:0] byte_sel(input logic [WORD_W-1:0] word,
                                                 input logic [2:0]        idx);
    return word[{idx, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/bus_to_sample_if.sv
// Valid/ready word handshake between an upstream source and bus_to_sample.
interface bus_to_sample_if;

  logic [bus_to_sample_pkg::WORD_W-1:0] in_word;
  logic                                 in_valid;
  logic                                 in_ready;

  modport master (output in_word, output in_valid, input in_ready);
  modport slave  (input in_word, input in_valid, output in_ready);

endinterface

// File: rtl/sample_tick_gen.sv
// Free-running divider: tick is high for one cycle every SAMPLE_DIV+1 fastclk cycles.
module sample_tick_gen #(
  parameter int unsigned SAMPLE_DIV = 6667,
  parameter int unsigned DIV_W      = 16
) (
  input  logic fastclk,
  input  logic reset,
  output logic tick
);

  logic [DIV_W-1:0] cnt_q;

  assign tick = (cnt_q == DIV_W'(SAMPLE_DIV));

  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/bus_to_sample.sv
// Unpacks 64-bit words into one byte per sample tick on bit0..bit7 with a one-deep word buffer.
// Define MSB_FIRST_EN to present in_word[63:56] first instead of in_word[7:0].
module bus_to_sample
  import bus_to_sample_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 6667,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                 fastclk,
  input  logic                 reset,
  bus_to_sample_if.slave       bus,
  output logic                 bit0,
  output logic                 bit1,
  output logic                 bit2,
  output logic                 bit3,
  output logic                 bit4,
  output logic                 bit5,
  output logic                 bit6,
  output logic                 bit7,
  output logic                 sample_strobe,
  output logic                 word_done,
  output logic                 underrun
);

  // Maps presentation slot (0 = first byte out) to byte lane within the word.
  function automatic logic [2:0] lane(input logic [2:0] slot);
`ifdef MSB_FIRST_EN
    return 3'd7 - slot;
`else
    return slot;
`endif
  endfunction

  logic              tick;
  state_e            state_q;
  logic [2:0]        byte_idx_q;
  logic [2:0]        byte_idx_nxt;
  logic [WORD_W-1:0] pending_q;
  logic              pending_valid_q;
  logic [WORD_W-1:0] shift_q;
  logic [BYTE_W-1:0] out_q;
  logic              strobe_q;
  logic              done_q;
  logic              underrun_q;
  logic              accept;

  sample_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV),
    .DIV_W      (DIV_W)
  ) u_tick (
    .fastclk (fastclk),
    .reset   (reset),
    .tick    (tick)
  );

  assign bus.in_ready = !pending_valid_q;
  assign accept       = bus.in_valid && !pending_valid_q;
  assign byte_idx_nxt = byte_idx_q + 3'd1;

  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      byte_idx_q      <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      shift_q         <= '0;
      out_q           <= '0;
      strobe_q        <= 1'b0;
      done_q          <= 1'b0;
      underrun_q      <= 1'b0;
    end else begin
      strobe_q   <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      // Accept and consume never coincide: consuming needs pending_valid_q, accept needs it clear.
      if (accept) begin
        pending_q       <= bus.in_word;
        pending_valid_q <= 1'b1;
      end
      if (tick) begin
        if (state_q == SHIFT && byte_idx_q != 3'd7) begin
          byte_idx_q <= byte_idx_nxt;
          out_q      <= byte_sel(shift_q, lane(byte_idx_nxt));
          strobe_q   <= 1'b1;
          done_q     <= (byte_idx_nxt == 3'd7);
        end else if (pending_valid_q) begin
          shift_q         <= pending_q;
          pending_valid_q <= 1'b0;
          byte_idx_q      <= '0;
          out_q           <= byte_sel(pending_q, lane(3'd0));
          strobe_q        <= 1'b1;
          state_q         <= SHIFT;
        end else begin
          state_q    <= IDLE;
          underrun_q <= 1'b1;
        end
      end
    end
  end

  assign {bit7, bit6, bit5, bit4, bit3, bit2, bit1, bit0} = out_q;
  assign sample_strobe = strobe_q;
  assign word_done     = done_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_bus_to_sample.sv
// Self-checking bench for bus_to_sample against a queue-based byte-stream model (SAMPLE_DIV=3).
module tb_bus_to_sample;

  localparam int unsigned DIV = 3;

  logic fastclk = 1'b0;
  logic reset   = 1'b0;
  always #5 fastclk = ~fastclk;

  bus_to_sample_if bus ();

  logic bit0, bit1, bit2, bit3, bit4, bit5, bit6, bit7;
  logic sample_strobe, word_done, underrun;

  bus_to_sample #(
    .SAMPLE_DIV (DIV),
    .DIV_W      (16)
  ) dut (
    .fastclk       (fastclk),
    .reset         (reset),
    .bus           (bus),
    .bit0          (bit0),
    .bit1          (bit1),
    .bit2          (bit2),
    .bit3          (bit3),
    .bit4          (bit4),
    .bit5          (bit5),
    .bit6          (bit6),
    .bit7          (bit7),
    .sample_strobe (sample_strobe),
    .word_done     (word_done),
    .underrun      (underrun)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: bytes still to play from the current word, plus the one-deep buffer.
  logic [7:0]  play_q[$];
  logic [63:0] pend_m;
  logic        pend_v_m;
  logic [7:0]  out_m;
  logic        strobe_m, done_m, und_m;
  int          cnt_m;
  logic [63:0] src[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".bits"}, 64'({bit7, bit6, bit5, bit4, bit3, bit2, bit1, bit0}), 64'(out_m));
    check({tag, ".strobe"}, 64'(sample_strobe), 64'(strobe_m));
    check({tag, ".done"}, 64'(word_done), 64'(done_m));
    check({tag, ".underrun"}, 64'(underrun), 64'(und_m));
    check({tag, ".ready"}, 64'(bus.in_ready), 64'(!pend_v_m));
  endtask

  task automatic model_clear();
    play_q.delete();
    src.delete();
    pend_m   = '0;
    pend_v_m = 1'b0;
    out_m    = '0;
    strobe_m = 1'b0;
    done_m   = 1'b0;
    und_m    = 1'b0;
    cnt_m    = 0;
  endtask

  task automatic load_play(input logic [63:0] w);
    for (int k = 0; k < 8; k++) begin
`ifdef MSB_FIRST_EN
      play_q.push_back(w[8*(7-k) +: 8]);
`else
      play_q.push_back(w[8*k +: 8]);
`endif
    end
  endtask

  // One clock cycle: source offers src[0] with probability pct, model advances, DUT is checked.
  task automatic cycle(input int pct, input string tag);
    logic        tick, acc;
    logic [63:0] w;
    if (src.size() > 0 && int'($urandom_range(99)) < pct) begin
      bus.in_valid = 1'b1;
      bus.in_word  = src[0];
    end else begin
      bus.in_valid = 1'b0;
      bus.in_word  = {$urandom, $urandom};
    end
    tick = (cnt_m == DIV);
    acc  = bus.in_valid && !pend_v_m;
    w    = bus.in_word;
    @(posedge fastclk);
    #1;
    strobe_m = 1'b0;
    done_m   = 1'b0;
    und_m    = 1'b0;
    if (tick) begin
      if (play_q.size() == 0 && pend_v_m) begin
        load_play(pend_m);
        pend_v_m = 1'b0;
      end
      if (play_q.size() > 0) begin
        out_m    = play_q.pop_front();
        strobe_m = 1'b1;
        done_m   = (play_q.size() == 0);
      end else begin
        und_m = 1'b1;
      end
    end
    if (acc) begin
      pend_m   = w;
      pend_v_m = 1'b1;
      void'(src.pop_front());
    end
    cnt_m = tick ? 0 : cnt_m + 1;
    check_all(tag);
  endtask

  task automatic mid_reset();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    model_clear();
    check_all("async_reset");
    @(posedge fastclk);
    #1;
    check_all("held_reset");
    reset = 1'b1;
  endtask

  int n_strobe, n_und;
  logic [7:0] last_byte;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_word  = '0;
    model_clear();
    repeat (2) @(posedge fastclk);
    #1;
    check_all("reset");
    reset = 1'b1;

    // Idle: periodic underrun, outputs stay zero.
    for (int i = 0; i < 20; i++) cycle(0, "idle");

    // Single word, then underrun and hold of the final byte.
    src.push_back(64'h0807060504030201);
    for (int i = 0; i < 48; i++) cycle(100, "single");
`ifdef MSB_FIRST_EN
    last_byte = 8'h01;
`else
    last_byte = 8'h08;
`endif
    check("single_hold", 64'({bit7, bit6, bit5, bit4, bit3, bit2, bit1, bit0}), 64'(last_byte));

    // Back-to-back A then B with in_valid held high.
    src.push_back({$urandom, $urandom});
    src.push_back({$urandom, $urandom});
    n_strobe = 0;
    n_und    = 0;
    for (int i = 0; i < 200 && n_strobe < 16; i++) begin
      cycle(100, "b2b");
      if (sample_strobe === 1'b1) n_strobe++;
      else if (underrun === 1'b1 && n_strobe > 0) n_und++;
    end
    check("b2b_strobes", 64'(n_strobe), 64'd16);
    check("b2b_underruns", 64'(n_und), 64'd0);
    for (int i = 0; i < 8; i++) cycle(0, "b2b_tail");

    // Word offered exactly on a tick cycle from IDLE.
    for (int i = 0; i < 8 && cnt_m != DIV; i++) cycle(0, "align");
    check("align_reached", 64'(cnt_m), 64'(DIV));
    src.push_back({$urandom, $urandom});
    cycle(100, "tick_accept");
    check("tick_accept_no_present", 64'(sample_strobe), 64'd0);
    for (int i = 0; i < 40; i++) cycle(0, "tick_accept_play");

    // Reset after byte 3 with a pending word; next word restarts at byte 0.
    src.push_back({$urandom, $urandom});
    src.push_back({$urandom, $urandom});
    for (int i = 0; i < 100 && !(play_q.size() == 4 && pend_v_m); i++) cycle(100, "pre_reset");
    check("pre_reset_reached", 64'(play_q.size() == 4 && pend_v_m), 64'd1);
    mid_reset();
    src.push_back({$urandom, $urandom});
    for (int i = 0; i < 45; i++) cycle(100, "post_reset");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if (src.size() < 2 && $urandom_range(3) == 0) src.push_back({$urandom, $urandom});
      cycle(70, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bus_to_sample.md
Name: bus_to_sample

Overview:
- Unpacks 64-bit words, each holding eight 8-bit samples, into a stream of single bytes on eight 1-bit output pins.
- Emits one byte per sample period and paces output with an internal divider running on the 50 MHz fabric clock.
- Playback counterpart to the sample packer: byte k of a word sits at in_word[8k+7:8k]; byte 0 goes out first by default.
- One-deep word buffer plus a valid/ready handshake let the upstream source load the next word while the current one plays out.

Parameters:
- SAMPLE_DIV, 6667: sample tick every SAMPLE_DIV+1 fastclk cycles (≈7.5 kHz at 50 MHz); legal range 1..65535.
- DIV_W, 16: width of the divider counter; must satisfy 2^DIV_W > SAMPLE_DIV.

Ports:
- fastclk  in  1  fabric clock, 50 MHz; the only clock.
- reset  in  1  asynchronous, active-low reset.
- in_word  in  64  packed word; byte k = in_word[8k+7:8k].
- in_valid  in  1  in_word is valid this cycle.
- in_ready  out  1  block can accept a word this cycle.
- bit0..bit7  out  1 each  presented sample; bitN = byte[N].
- sample_strobe  out  1  one-cycle pulse when a new byte appears on bit0..bit7.
- word_done  out  1  one-cycle pulse, coincident with sample_strobe, when byte 7 of a word is presented.
- underrun  out  1  one-cycle pulse on a tick with no byte available.

Behaviour:
- Reset (reset=0, asynchronous):
  - divider=0, state=IDLE, byte_idx=0, pending_valid=0.
  - bit0..bit7=0; sample_strobe, word_done and underrun=0.
  - in_ready=1, because in_ready = !pending_valid.
- Divider:
  - Counts 0..SAMPLE_DIV. tick is combinational and high when counter==SAMPLE_DIV; the counter wraps to 0 on that cycle.
  - First tick falls SAMPLE_DIV cycles after reset release.
  - Counter is free-running and independent of data.
- Handshake:
  - A word is accepted on a rising edge where in_valid && in_ready; it goes into the pending register and pending_valid=1.
  - in_word is ignored when in_ready=0.
  - The source may hold in_valid high; no combinational path from in_valid to in_ready.
- State machine: IDLE, SHIFT. byte_idx 0..7 indexes the byte currently presented. All transitions occur only on tick.
  - SHIFT && byte_idx<7: byte_idx+1; present that byte; sample_strobe=1; word_done=1 iff new byte_idx==7.
  - (IDLE or byte_idx==7) && pending_valid: copy pending to shift register; clear pending_valid; byte_idx=0; present byte 0; sample_strobe=1; state=SHIFT.
  - (IDLE or byte_idx==7) && !pending_valid: state=IDLE; underrun=1; bit0..bit7 hold the last byte.
- Output timing:
  - bit0..bit7 are registered and change only on tick edges.
  - Each byte is held exactly SAMPLE_DIV+1 cycles while words stream back-to-back.
- Simultaneous events:
  - Word accepted on the same cycle as a tick from IDLE: lands in pending, is not presented on that tick; first byte appears on the next tick.
  - Tick consuming pending in the same cycle as in_valid: in_ready was 0, so no accept; in_ready rises the next cycle.
- Throughput: a word accepted any time before byte 7's tick period ends plays gaplessly.
- Reset mid-word: all state is discarded, outputs return to 0, and the pending word is lost.

Optional Feature:
- MSB_FIRST_EN defined: byte presentation order reversed; in_word[63:56] first, in_word[7:0] last. word_done still pulses on the eighth byte presented.
- Not defined: byte 0 (in_word[7:0]) first.
- Bit order within each byte is unchanged in both cases.

Decomposition:
- Package bus_to_sample_pkg:
  - state enum {IDLE, SHIFT}.
  - BYTES_PER_WORD=8, BYTE_W=8, WORD_W=64.
  - byte-select helper function.
- Sub-module sample_tick_gen (parameters SAMPLE_DIV, DIV_W; ports fastclk, reset, tick). Reusable by the packer to replace its derived clock.

Test Plan:
- All tests run with SAMPLE_DIV=3 (tick every 4 cycles) unless noted.
- Reset then idle: in_valid=0 for 20 cycles -> outputs stay 0, in_ready=1, underrun pulses every 4 cycles from cycle 3.
- Single word 64'h0807060504030201 -> bits read 01,02,…,08 on consecutive ticks; 8 sample_strobe pulses; word_done with 08; underrun on the following tick; output holds 08.
- Back-to-back words A then B, in_valid held high -> 16 strobes with no underrun; B accepted while A plays; in_ready low from B accept until the tick that presents B byte 0.
- Word accepted on the exact tick cycle from IDLE -> first byte appears one tick later, not on that tick.
- reset asserted after byte 3 with a pending word -> immediate zero outputs, in_ready=1; next word starts at byte 0.
- MSB_FIRST_EN defined, word 64'h0807060504030201 -> presentation order 08,07,…,01; word_done coincides with 01.
